// File: rtl/chain_ctrl_pkg.sv
// Purpose: shared types and constants for the chain_ctrl run controller.
// Contents: FSM state enum, LED bit positions, default timing parameters.
// Used by: chain_ctrl (top) and btn_debounce.
package chain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int LED_RUN     = 0;
  localparam int LED_DONE    = 1;
  localparam int LED_ERR     = 2;
  localparam int LED_CNT_LSB = 3;
  localparam int LED_CNT_MAX = 31;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 4096;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: debounce one asynchronous push-button and emit a one-cycle press pulse.
// Ports: clk_i/reset_i (sync, active-high), btn_i raw button, pulse_o rising-edge
//        pulse of the accepted level (2 sync + DEBOUNCE_CYCLES + 1 cycles after press).
import chain_ctrl_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      meta_q      <= btn_i;
      sync_q      <= meta_q;
      level_dly_q <= level_q;
      // Any sample agreeing with the accepted level restarts the stability window,
      // so a glitch shorter than DEBOUNCE_CYCLES never reaches the level.
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = level_q & ~level_dly_q;

endmodule

// File: rtl/chain_ctrl.sv
// Purpose: button-driven run controller issuing NEVENTS ap_start/ap_done handshakes
//          to the HLS chain, with per-event hang timeout and status LEDs.
// Ports: clk/reset (sync, active-high), sw_N start / sw_C clear buttons, ap_* chain
//        handshake, bx bunch crossing, LED {count[4:0], err, done, running}.
import chain_ctrl_pkg::*;

module chain_ctrl #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NEVENTS         = 8,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int BX_WIDTH        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_N,
  input  logic                sw_C,
  output logic                ap_start,
  input  logic                ap_ready,
  input  logic                ap_done,
  input  logic                ap_idle,
  output logic [BX_WIDTH-1:0] bx,
  output logic [7:0]          LED
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic n_pulse;
  logic c_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
    .clk_i  (clk),
    .reset_i(reset),
    .btn_i  (sw_N),
    .pulse_o(n_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk_i  (clk),
    .reset_i(reset),
    .btn_i  (sw_C),
    .pulse_o(c_pulse)
  );

  state_e                state_q, state_d;
  logic [BX_WIDTH-1:0]   bx_q, bx_d;
  logic [7:0]            evt_q, evt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  run_q, run_d;
  logic                  evt_fire;
  logic                  timed_out;

  assign timed_out = (tmr_q >= TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    evt_d    = evt_q;
    tmr_d    = tmr_q;
    run_d    = run_q;
    evt_fire = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (n_pulse && ap_idle) begin
          state_d = ST_START;
          tmr_d   = '0;
          evt_d   = '0;
          run_d   = 1'b1;
        end
      end
      ST_START: begin
        if (timed_out) begin
          state_d = ST_ERROR;
        end else begin
          tmr_d = tmr_q + TW'(1);
          // ready+done together completes the event without visiting WAIT
          if (ap_ready && ap_done) evt_fire = 1'b1;
          else if (ap_ready)       state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timed_out) begin
          state_d = ST_ERROR;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (ap_done) evt_fire = 1'b1;
        end
      end
      ST_DONE, ST_ERROR: begin
        // terminal until cleared; n_pulse is ignored
      end
      default: state_d = ST_IDLE;
    endcase

    if (evt_fire) begin
      bx_d  = bx_q + BX_WIDTH'(1);
      evt_d = evt_q + 8'd1;
      if (({1'b0, evt_q} + 9'd1) == 9'(NEVENTS)) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_START;
        tmr_d   = '0;
      end
    end

    // Clear dominates everything, including a coincident start press.
    if (c_pulse) begin
      state_d = ST_IDLE;
      bx_d    = '0;
      evt_d   = '0;
      tmr_d   = '0;
      run_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      evt_q   <= '0;
      tmr_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      evt_q   <= evt_d;
      tmr_q   <= tmr_d;
      run_q   <= run_d;
    end
  end

  assign ap_start = (state_q == ST_START);
  assign bx       = bx_q;

  always_comb begin
    LED                  = '0;
    LED[LED_RUN]         = run_q;
    LED[LED_DONE]        = (state_q == ST_DONE);
    LED[LED_ERR]         = (state_q == ST_ERROR);
    LED[7:LED_CNT_LSB]   = (evt_q > 8'(LED_CNT_MAX)) ? 5'(LED_CNT_MAX) : evt_q[4:0];
  end

endmodule

// File: tb/tb_chain_ctrl.sv
module tb_chain_ctrl;

  localparam int NEV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_N;
  logic       sw_C;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_done;
  logic       ap_idle;
  logic [2:0] bx;
  logic [7:0] LED;

  int checks   = 0;
  int failures = 0;

  // chain model controls and observations
  int rd_lo, rd_hi, dd_lo, dd_hi;
  bit never_done, same_cycle, flush;
  int hs_cnt, done_cnt, start_cycles;
  int bx_log[$];

  always #5 clk = ~clk;

  chain_ctrl #(
    .DEBOUNCE_CYCLES(64),
    .NEVENTS        (NEV),
    .TIMEOUT_CYCLES (100),
    .BX_WIDTH       (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_N    (sw_N),
    .sw_C    (sw_C),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done (ap_done),
    .ap_idle (ap_idle),
    .bx      (bx),
    .LED     (LED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LED as a function of run status: {count saturated at 31, err, done, running}
  function automatic logic [7:0] led_model(input int events, input bit run, input bit done, input bit err);
    int c;
    logic [4:0] c5;
    c  = (events > 31) ? 31 : events;
    c5 = 5'(c);
    return {c5, err, done, run};
  endfunction

  // Behavioural HLS chain: acknowledges ap_start after a random delay, completes after another.
  initial begin
    int ph;
    int dly;
    ph = 0;
    dly = 0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    forever begin
      @(negedge clk);
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (reset || flush) begin
        ph = 0;
      end else begin
        if (ap_start) start_cycles++;
        if (same_cycle) begin
          if (ap_start) begin
            ap_ready = 1'b1;
            ap_done  = 1'b1;
            hs_cnt++;
            done_cnt++;
            bx_log.push_back(int'(bx));
          end
        end else begin
          if (ph == 0 && ap_start) begin
            dly = $urandom_range(rd_hi, rd_lo);
            ph  = 1;
          end
          if (ph == 1) begin
            if (!ap_start) ph = 0;
            else if (dly == 0) begin
              ap_ready = 1'b1;
              hs_cnt++;
              ph  = 2;
              dly = $urandom_range(dd_hi, dd_lo);
            end else dly--;
          end else if (ph == 2 && !never_done) begin
            if (dly <= 1) begin
              ap_done = 1'b1;
              done_cnt++;
              bx_log.push_back(int'(bx));
              ph = 0;
            end else dly--;
          end
        end
      end
    end
  end

  task automatic reset_counters();
    hs_cnt = 0;
    done_cnt = 0;
    start_cycles = 0;
    bx_log.delete();
  endtask

  task automatic clear_all();
    sw_C = 1'b1;
    repeat (80) @(negedge clk);
    sw_C = 1'b0;
    repeat (80) @(negedge clk);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    reset_counters();
  endtask

  // Press start, wait for the run to finish and compare against the model (bx base 0).
  task automatic run_full(input string tag, input int hold);
    int k;
    k = 0;
    sw_N = 1'b1;
    while (LED[1] !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
      if (k == hold) sw_N = 1'b0;
    end
    sw_N = 1'b0;
    chk({tag, "_finished"}, 32'(LED[1]), 32'd1);
    chk({tag, "_led"}, 32'(LED), 32'(led_model(NEV, 1, 1, 0)));
    chk({tag, "_handshakes"}, hs_cnt, NEV);
    chk({tag, "_bx_wrap"}, 32'(bx), 32'(NEV % 8));
    chk({tag, "_bx_log_len"}, bx_log.size(), NEV);
    for (int i = 0; i < bx_log.size(); i++) chk({tag, "_bx_seq"}, bx_log[i], i % 8);
    repeat (80) @(negedge clk);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    sw_N = 1'b0;
    sw_C = 1'b0;
    ap_idle = 1'b1;
    rd_lo = 1; rd_hi = 1; dd_lo = 20; dd_hi = 20;
    never_done = 0; same_cycle = 0; flush = 0;
    reset_counters();
    repeat (5) @(negedge clk);
    chk("rst_ap_start", 32'(ap_start), 32'd0);
    chk("rst_bx", 32'(bx), 32'd0);
    chk("rst_led", 32'(LED), 32'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 10-cycle glitch must be rejected
    sw_N = 1'b1;
    repeat (10) @(negedge clk);
    sw_N = 1'b0;
    repeat (100) @(negedge clk);
    chk("glitch_no_start", start_cycles, 0);
    chk("glitch_led", 32'(LED), 32'h00);

    // chain busy: a valid press is refused
    ap_idle = 1'b0;
    sw_N = 1'b1;
    repeat (100) @(negedge clk);
    sw_N = 1'b0;
    repeat (80) @(negedge clk);
    chk("busy_no_start", start_cycles, 0);
    ap_idle = 1'b1;

    // run 1: ready after 1, done after 20, 250-cycle press
    run_full("run1", 250);
    sw_N = 1'b1;
    repeat (100) @(negedge clk);
    sw_N = 1'b0;
    repeat (80) @(negedge clk);
    chk("done_ignores_start", hs_cnt, NEV);
    chk("done_led_held", 32'(LED), 32'(led_model(NEV, 1, 1, 0)));

    clear_all();
    chk("clr_led", 32'(LED), 32'h00);
    chk("clr_bx", 32'(bx), 32'd0);
    chk("clr_ap_start", 32'(ap_start), 32'd0);

    // clear pressed mid-run after the third event
    rd_lo = 0; rd_hi = 3; dd_lo = 20; dd_hi = 40;
    sw_N = 1'b1;
    k = 0;
    while (done_cnt < 3 && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == 100) sw_N = 1'b0;
    end
    sw_N = 1'b0;
    chk("mid_reached_evt3", 32'(done_cnt >= 3), 32'd1);
    sw_C = 1'b1;
    k = 0;
    while (LED !== 8'h00 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("mid_was_running", 32'(done_cnt < NEV), 32'd1);
    chk("mid_clr_led", 32'(LED), 32'h00);
    chk("mid_clr_ap_start", 32'(ap_start), 32'd0);
    chk("mid_clr_bx", 32'(bx), 32'd0);
    repeat (80) @(negedge clk);
    sw_C = 1'b0;
    repeat (80) @(negedge clk);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    reset_counters();

    // fresh run after clear with random latencies
    rd_lo = 0; rd_hi = 3; dd_lo = 1; dd_hi = 15;
    run_full("run2", 100);
    clear_all();

    // hang: chain never completes
    rd_lo = 1; rd_hi = 1;
    never_done = 1;
    sw_N = 1'b1;
    k = 0;
    while (ap_start !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("to_start_seen", 32'(ap_start), 32'd1);
    sw_N = 1'b0;
    repeat (100) @(negedge clk);
    chk("to_not_early", 32'(LED[2]), 32'd0);
    @(negedge clk);
    chk("to_err_led", 32'(LED[2]), 32'd1);
    chk("to_ap_start", 32'(ap_start), 32'd0);
    chk("to_done_led", 32'(LED[1]), 32'd0);
    repeat (80) @(negedge clk);
    sw_N = 1'b1;
    repeat (100) @(negedge clk);
    sw_N = 1'b0;
    repeat (80) @(negedge clk);
    chk("to_ignores_start", hs_cnt, 1);
    chk("to_err_held", 32'(LED[2]), 32'd1);
    chk("to_ap_start_held", 32'(ap_start), 32'd0);
    clear_all();
    never_done = 0;

    // ready and done together on every event
    same_cycle = 1;
    run_full("same", 100);
    chk("same_start_cycles", start_cycles, NEV);
    clear_all();
    same_cycle = 0;

    // reset in the middle of an event
    rd_lo = 1; rd_hi = 1; dd_lo = 20; dd_hi = 20;
    sw_N = 1'b1;
    k = 0;
    while (done_cnt < 2 && k < 1000) begin
      @(negedge clk);
      k++;
      if (k == 100) sw_N = 1'b0;
    end
    sw_N = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_bx", 32'(bx), 32'd2);
    chk("pre_rst_in_wait", 32'(ap_start), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ap_start", 32'(ap_start), 32'd0);
    chk("mid_rst_bx", 32'(bx), 32'd0);
    chk("mid_rst_led", 32'(LED), 32'h00);
    reset = 1'b0;
    reset_counters();
    repeat (30) @(negedge clk);
    chk("post_rst_idle", start_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chain_ctrl.md
# chain_ctrl

Board-level run controller feeding the TE→TC HLS chain inside the chain top level. Debounces the north (start) and centre (clear) push-buttons, issues a burst of NEVENTS ap_start/ap_done handshakes to the chain with an incrementing bunch-crossing number, watches for hangs, and drives the eight status LEDs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 64: consecutive stable synchronised samples required before a button level is accepted.
- NEVENTS, 8: events processed per run, range 1..255.
- TIMEOUT_CYCLES, 4096: maximum cycles allowed per event from ap_start to ap_done.
- BX_WIDTH, 3: bunch-crossing counter width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw_N  in  1  raw start button (asynchronous).
- sw_C  in  1  raw clear button (asynchronous).
- ap_start  out  1  HLS start to the chain.
- ap_ready  in  1  chain has accepted inputs.
- ap_done  in  1  chain has finished one event.
- ap_idle  in  1  chain is idle.
- bx  out  BX_WIDTH  bunch crossing of the current event.
- LED  out  8  status: [0] running, [1] run complete, [2] timeout error, [7:3] completed-event count.

## Operation
- Each button: 2-FF synchroniser, then a stability counter. The accepted level updates once the synchronised input has held a new value for DEBOUNCE_CYCLES cycles. A rising edge of the accepted level gives a one-cycle pulse (n_pulse, c_pulse).
- FSM states: IDLE, START, WAIT, DONE, ERROR.
  - IDLE: on n_pulse with ap_idle=1, go to START. On n_pulse with ap_idle=0, stay in IDLE.
  - START: ap_start=1. When ap_ready=1, go to WAIT; ap_start drops the next cycle.
  - WAIT: on ap_done, increment bx (modulo 2^BX_WIDTH) and the event count. If event count = NEVENTS go to DONE, else go to START.
  - If ap_ready and ap_done are high in the same START cycle, treat it as acceptance plus completion in that cycle, with no WAIT visit.
  - DONE: LED[1]=1. Ignore n_pulse.
  - ERROR: entered when the per-event timer reaches TIMEOUT_CYCLES in START or WAIT. ap_start=0, LED[2]=1. Ignore n_pulse.
- c_pulse in any state:
  - go to IDLE;
  - clear bx, the event count, the timer and all LEDs;
  - deassert ap_start the next cycle.
  - If n_pulse and c_pulse occur in the same cycle, the clear wins.
- Per-event timer: reset on entry to START, counts in START and WAIT, saturates.
- LED[7:3] = event count, saturating at 31. bx is not cleared between runs, except by c_pulse or reset.

## Timing
- Reset values: ap_start=0, bx=0, LED=8'h00, FSM=IDLE, debounced levels=0, counters=0.
- Button latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle gives n_pulse. ap_start rises 1 cycle after n_pulse.
- ap_start stays high until the cycle ap_ready is sampled high, inclusive, and is low the cycle after.
- Back-to-back events: ap_done in cycle t gives ap_start=1 in cycle t+1.
- bx and LED update 1 cycle after the ap_done sample.
- Entry to DONE/ERROR shows on the LEDs 1 cycle after the triggering sample.
- A reset asserted mid-run forces all outputs to their reset values on the next edge. Chain outputs are ignored while reset=1.

## Structure
- Shared package chain_ctrl_pkg holds:
  - FSM state enum;
  - LED bit index constants (LED_RUN=0, LED_DONE=1, LED_ERR=2, LED_CNT_LSB=3);
  - default DEBOUNCE_CYCLES and TIMEOUT_CYCLES.
- One sub-module, btn_debounce: synchroniser, stability counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. Instantiate it twice.

## Test plan
- Press sw_N for 250 cycles with DEBOUNCE_CYCLES=64 and the chain model answering ap_ready after 1 cycle and ap_done after 20 → exactly 8 ap_start handshakes, bx goes 0..7 then wraps to 0, LED=8'b01000011 (count 8, done, running held).
- Glitch sw_N for 10 cycles → no n_pulse, ap_start stays 0, LED=0.
- Chain model never raises ap_done with TIMEOUT_CYCLES=100 → ERROR 101 cycles after START entry, LED[2]=1, ap_start=0. A later sw_N press is ignored.
- Press sw_C mid-run at event 3 → ap_start=0 within 1 cycle, LED=0, bx=0. A following sw_N starts a new 8-event run.
- Raise ap_ready and ap_done in the same cycle on every event → run completes with no WAIT state, ap_start high exactly 1 cycle per event.
- Assert reset during WAIT → next cycle ap_start=0, bx=0, LED=0, FSM=IDLE.
